summator_driver: RTL and testbench

//   Parallel-to-serial front end for the bit-serial summator.
//   - Accepts two parallel operands on a valid/ready handshake.
//   - Shifts both operands out LSB-first on r1/r2, then pads with one zero bit.
//   - Captures the serial sum, returns it as a parallel result, and flags any

---
 rtl/summator_driver.sv | 122 ++++++++++++
 tb/tb_summator_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/summator_driver.sv
// summator_driver: parallel-to-serial front end for the bit-serial summator.
// Operands are shifted out LSB-first on r1/r2 and followed by a zero pad bit.
// The returning serial sum is collected into a parallel result and checked
// against a locally computed a+b.
module summator_driver #(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [reglength-1:0] a_in,
    input  logic [reglength-1:0] b_in,
    output logic                 r1,
    output logic                 r2,
    input  logic                 sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [reglength:0]   result,
    output logic                 err
);

    localparam int cntw = $clog2(reglength + 1);
    localparam logic [cntw-1:0] last_shift = cntw'(reglength - 1);
    localparam logic [cntw-1:0] last_cap   = cntw'(reglength);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PAD,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [cntw-1:0]       cnt;
    logic [reglength-1:0]  shift_a;
    logic [reglength-1:0]  shift_b;
    logic [reglength-1:0]  ref_a;
    logic [reglength-1:0]  ref_b;

    // State register; reset always returns to IDLE and discards the transaction
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and the handshake flags, which depend on state only
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = SHIFT;
            end
            SHIFT:   if (cnt == last_shift) next_state = PAD;
            PAD:     next_state = CAPTURE;
            CAPTURE: if (cnt == last_cap) next_state = FLUSH;
            FLUSH:   next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Phase counter restarts at zero whenever the state changes
    always_ff @(posedge clk) begin
        if (rst)                      cnt <= '0;
        else if (next_state != state) cnt <= '0;
        else if (state == SHIFT || state == CAPTURE) cnt <= cnt + 1'b1;
    end

    // Datapath: r1/r2 lead the shift registers by one bit so that they are
    // already carrying operand bit 0 in the first SHIFT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r1      <= 1'b0;
            r2      <= 1'b0;
            shift_a <= '0;
            shift_b <= '0;
            ref_a   <= '0;
            ref_b   <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            r1 <= 1'b0;
            r2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r1      <= a_in[0];
                        r2      <= b_in[0];
                        shift_a <= a_in >> 1;
                        shift_b <= b_in >> 1;
                        ref_a   <= a_in;
                        ref_b   <= b_in;
                        result  <= '0;
                        err     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != last_shift) begin
                        r1      <= shift_a[0];
                        r2      <= shift_b[0];
                        shift_a <= shift_a >> 1;
                        shift_b <= shift_b >> 1;
                    end
                end
                CAPTURE: result[cnt] <= sum;
                FLUSH:   err <= (result != ({1'b0, ref_a} + {1'b0, ref_b}));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_summator_driver.sv
// Testbench for summator_driver with a behavioural serial summator whose
// sum output trails its inputs by reglength+1 cycles.
module tb_summator_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a_in;
    logic [2:0] b_in;
    logic       r1;
    logic       r2;
    logic       sum_bit;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic       carry  = 1'b0;
    logic [3:0] dly    = 4'b0;
    logic       faulty = 1'b0;
    logic [2:0] r1_seq;
    logic [2:0] r2_seq;
    int         lat;
    int         accepts;
    int         results;

    summator_driver #(.reglength(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .r1        (r1),
        .r2        (r2),
        .sum       (sum_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference serial summator: full adder with carry register, delayed 4 cycles
    always @(posedge clk) begin
        carry <= (r1 & r2) | (r1 & carry) | (r2 & carry);
        dly   <= {dly[2:0], r1 ^ r2 ^ carry};
    end

    assign sum_bit = faulty ? 1'b0 : dly[3];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                                 input logic rdy, output int cycles);
        @(negedge clk);
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        out_ready = rdy;
        cycles    = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cycles++;
            if (cycles <= 3) begin
                r1_seq[cycles-1] = r1;
                r2_seq[cycles-1] = r2;
            end
        end while (!out_valid && cycles < 40);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 3'd0;
        b_in      = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_r1", r1, 0);
        checkOutput("rst_r2", r2, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3+5: serial sequences, latency and result
        applyStimulus(3'd3, 3'd5, 1'b1, lat);
        checkOutput("r1_seq_3", r1_seq, 3'b011);
        checkOutput("r2_seq_5", r2_seq, 3'b101);
        checkOutput("latency_3p5", lat, 10);
        checkOutput("result_3p5", result, 4'b1000);
        checkOutput("err_3p5", err, 0);

        // Exhaustive back-to-back operands
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus(3'(a), 3'(b), 1'b1, lat);
                checkOutput($sformatf("lat_%0d_%0d", a, b), lat, 10);
                checkOutput($sformatf("res_%0d_%0d", a, b), result, 32'(a + b));
                checkOutput($sformatf("err_%0d_%0d", a, b), err, 0);
            end
        end
        applyStimulus(3'd7, 3'd7, 1'b1, lat);
        checkOutput("result_7p7", result, 4'b1110);

        // Consumer stalls for 5 cycles; a new in_valid meanwhile is ignored
        applyStimulus(3'd6, 3'd3, 1'b0, lat);
        checkOutput("stall_latency", lat, 10);
        a_in     = 3'd1;
        b_in     = 3'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_result", result, 4'd9);
            checkOutput("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("exit_out_valid", out_valid, 0);
        checkOutput("exit_in_ready", in_ready, 1);
        @(negedge clk);
        checkOutput("no_ghost_accept", in_ready, 1);

        // Reset during SHIFT at cnt=1
        a_in     = 3'd3;
        b_in     = 3'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_r1", r1, 0);
        checkOutput("midrst_r2", r2, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        applyStimulus(3'd2, 3'd2, 1'b1, lat);
        checkOutput("after_rst_lat", lat, 10);
        checkOutput("after_rst_result", result, 4'd4);
        checkOutput("after_rst_err", err, 0);

        // Summator stuck at zero must be flagged
        faulty = 1'b1;
        applyStimulus(3'd1, 3'd1, 1'b1, lat);
        checkOutput("faulty_result", result, 4'd0);
        checkOutput("faulty_err", err, 1);
        faulty = 1'b0;

        // in_valid held high: one accept and one result every 11 cycles
        accepts = 0;
        results = 0;
        @(negedge clk);
        a_in      = 3'd1;
        b_in      = 3'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (in_valid && in_ready) accepts++;
            if (out_valid) begin
                results++;
                checkOutput("cont_result", result, 4'd7);
                checkOutput("cont_err", err, 0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("cont_accepts", accepts, 3);
        checkOutput("cont_results", results, 3);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
